// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter with bounded hold in front of a single-port,
// 1-cycle-read on-chip RAM (Avalon-MM style waitrequest/readdatavalid handshake).
module onchip_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned HOLD_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_WIDTH-1:0] mem_readdata
);

  localparam int unsigned CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pend0_q, pend0_d, pend1_q, pend1_d;
  logic             req0, req1, grant0, grant1;

  // Requests are masked during reset so the bus looks idle while it is held.
  always_comb begin
    req0         = (m0_read | m0_write) & ~reset;
    req1         = (m1_read | m1_write) & ~reset;
    grant0       = 1'b0;
    grant1       = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;

    if (req0 && req1) begin
      case (state_q)
        OWN0:    if (hold_cnt_q < CNT_LAST) grant0 = 1'b1; else grant1 = 1'b1;
        OWN1:    if (hold_cnt_q < CNT_LAST) grant1 = 1'b1; else grant0 = 1'b1;
        default: if (last_grant_q) grant0 = 1'b1; else grant1 = 1'b1;
      endcase
    end else begin
      grant0 = req0;
      grant1 = req1;
    end

    if (grant0) begin
      if (state_q == OWN0) begin
        hold_cnt_d = (hold_cnt_q == CNT_LAST) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
      end else begin
        state_d      = OWN0;
        hold_cnt_d   = '0;
        last_grant_d = 1'b0;
      end
    end else if (grant1) begin
      if (state_q == OWN1) begin
        hold_cnt_d = (hold_cnt_q == CNT_LAST) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
      end else begin
        state_d      = OWN1;
        hold_cnt_d   = '0;
        last_grant_d = 1'b1;
      end
    end else begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end

    // Read+write together is a write, so only a pure read leaves a response pending.
    pend0_d = grant0 & m0_read & ~m0_write;
    pend1_d = grant1 & m1_read & ~m1_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      hold_cnt_q   <= '0;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
    end
  end

  // Memory-side mux: the granted master drives the RAM in the accept cycle.
  always_comb begin
    mem_chipselect = grant0 | grant1;
    mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    mem_address    = grant1 ? m1_address    : m0_address;
    mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  end

  assign mem_clken        = 1'b1;
  assign m0_waitrequest   = req0 & ~grant0;
  assign m1_waitrequest   = req1 & ~grant1;
  assign m0_readdatavalid = pend0_q & ~reset;
  assign m1_readdatavalid = pend1_q & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter: directed scenarios plus a randomized
// two-master run checked against a grant/streak reference model and a shadow memory.
module tb_onchip_memory_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned HM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  onchip_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // RAM model: registered q, byte-lane writes, preloaded with addr*3 on the first edge.
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ram_q = '0;
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= DW'(i * 3);
      ram_loaded <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < int'(BW); b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_q;

  logic [DW-1:0] gold [0:4095];

  task automatic drive(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 12'h001, 4'hF, '0);
    drive(1, 1'b0, 1'b1, 12'h002, 4'hF, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
           mem_chipselect, mem_write, mem_clken};
    n_checks++;
    if (obs !== 7'b0000001) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000001", obs);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    drive(0, 1'b0, 1'b1, 12'h000, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b011 || mem_address !== 12'h000) begin
      n_fail++; $display("FAIL wr_accept: wait=%b cs=%b we=%b addr=%h expected 0 1 1 000",
                         m0_waitrequest, mem_chipselect, mem_write, mem_address);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h000, 4'hF, '0);
    @(negedge clk);
    n_checks++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL rd_accept: wait0=%b wait1=%b valid0=%b we=%b expected 0000",
                         m0_waitrequest, m1_waitrequest, m0_readdatavalid, mem_write);
    end
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_data: valid0=%b valid1=%b data=%h expected 1 0 deadbeef",
                         m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    drive(0, 1'b1, 1'b0, 12'h041, 4'hF, '0);
    drive(1, 1'b1, 1'b0, 12'h042, 4'hF, '0);
    @(negedge clk);
    n_checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
      n_fail++; $display("FAIL tie_first: wait0/1=%b expected 01", {m0_waitrequest, m1_waitrequest});
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_checks++;
    if ({m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 3'b010 ||
        m0_readdata !== DW'(32'h41 * 3)) begin
      n_fail++; $display("FAIL tie_second: wait1=%b v0=%b v1=%b data=%h expected 0 1 0 %h",
                         m1_waitrequest, m0_readdatavalid, m1_readdatavalid, m0_readdata, 32'h41 * 3);
    end
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== DW'(32'h42 * 3)) begin
      n_fail++; $display("FAIL tie_third: v0=%b v1=%b data=%h expected 0 1 %h",
                         m0_readdatavalid, m1_readdatavalid, m1_readdata, 32'h42 * 3);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a0, a1, prev_a;
    int g, pg, wc0, wc1, maxw;
    do_reset();
    a0 = 12'h080; a1 = 12'h0C0; pg = -1; wc0 = 0; wc1 = 0; maxw = 0; prev_a = '0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'b1, 1'b0, a0, 4'hF, '0);
      drive(1, 1'b1, 1'b0, a1, 4'hF, '0);
      g = (k / int'(HM)) % 2;
      @(negedge clk);
      n_checks++;
      if ({m0_waitrequest, m1_waitrequest} !== {1'(g != 0), 1'(g != 1)}) begin
        n_fail++; $display("FAIL rr_grant cycle %0d: wait0/1=%b expected owner %0d",
                           k, {m0_waitrequest, m1_waitrequest}, g);
      end
      if (pg >= 0) begin
        n_checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== {1'(pg == 0), 1'(pg == 1)} ||
            m0_readdata !== DW'(prev_a) * 3) begin
          n_fail++; $display("FAIL rr_data cycle %0d: valid=%b data=%h expected master %0d data %h",
                             k, {m0_readdatavalid, m1_readdatavalid}, m0_readdata, pg, DW'(prev_a) * 3);
        end
      end
      if (m0_waitrequest) wc0++; else wc0 = 0;
      if (m1_waitrequest) wc1++; else wc1 = 0;
      if (wc0 > maxw) maxw = wc0;
      if (wc1 > maxw) maxw = wc1;
      prev_a = (g == 0) ? a0 : a1;
      pg = g;
      @(posedge clk); #1;
      if (g == 0) a0 = a0 + AW'(1); else a1 = a1 + AW'(1);
    end
    idle_all();
    n_checks++;
    if (maxw > int'(HM)) begin
      n_fail++; $display("FAIL rr_starvation: max wait %0d cycles, limit %0d", maxw, HM);
    end
  endtask

  task automatic test_byte_merge();
    do_reset();
    drive(0, 1'b0, 1'b1, 12'h010, 4'hF, 32'h11223344);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 12'h010, 4'b0101, 32'hAABBCCDD);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h010, 4'hF, '0);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    n_checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL byte_merge: valid=%b data=%h expected 1 11bb33dd",
                         m0_readdatavalid, m0_readdata);
    end
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    drive(1, 1'b1, 1'b0, 12'h043, 4'hF, '0);
    @(negedge clk);
    n_checks++;
    if (m1_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL rst_pend_accept: wait1=%b expected 0", m1_waitrequest);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({m0_readdatavalid, m1_readdatavalid, mem_chipselect, mem_write, mem_clken} !== 5'b00001) begin
      n_fail++; $display("FAIL rst_pend_suppress: v0 v1 cs we clken=%b expected 00001",
                         {m0_readdatavalid, m1_readdatavalid, mem_chipselect, mem_write, mem_clken});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_pend_after: valid=%b expected 00", {m0_readdatavalid, m1_readdatavalid});
    end
  endtask

  task automatic test_read_write_both();
    do_reset();
    drive(0, 1'b1, 1'b1, 12'h020, 4'hF, 32'h5A5A5A5A);
    @(negedge clk);
    n_checks++;
    if ({mem_chipselect, mem_write} !== 2'b11) begin
      n_fail++; $display("FAIL rw_both_write: cs/we=%b expected 11", {mem_chipselect, mem_write});
    end
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    n_checks++;
    if (m0_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rw_both_novalid: valid0=%b expected 0", m0_readdatavalid);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h020, 4'hF, '0);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    n_checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL rw_both_readback: valid=%b data=%h expected 1 5a5a5a5a",
                         m0_readdatavalid, m0_readdata);
    end
  endtask

  // Randomized masters that hold requests under waitrequest, checked against a model that
  // tracks the last winner and its streak of consecutive grants.
  task automatic test_random();
    logic          busy [2], op_rd [2], op_wr [2];
    logic [AW-1:0] ad [2];
    logic [BW-1:0] be [2];
    logic [DW-1:0] wd [2];
    logic          exp_v [2], nxt_v [2], eg [2];
    logic [DW-1:0] exp_d [2], nxt_d [2];
    int            last, streak, w, wc [2], op;
    logic          ow [2], ov [2];
    logic [DW-1:0] od [2];
    do_reset();
    last = 1; streak = 0;
    for (int m = 0; m < 2; m++) begin
      busy[m] = 1'b0; exp_v[m] = 1'b0; exp_d[m] = '0; wc[m] = 0;
      op_rd[m] = 1'b0; op_wr[m] = 1'b0; ad[m] = '0; be[m] = '0; wd[m] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!busy[m] && $urandom_range(0, 3) != 0) begin
          busy[m]  = 1'b1;
          op       = int'($urandom_range(0, 4));
          op_wr[m] = (op >= 2);
          op_rd[m] = (op != 2 && op != 3);
          ad[m]    = AW'(12'h100 + $urandom_range(0, 15));
          be[m]    = BW'($urandom_range(1, 15));
          wd[m]    = $urandom;
        end
        drive(m, busy[m] & op_rd[m], busy[m] & op_wr[m], ad[m], be[m], wd[m]);
      end
      if (busy[0] && busy[1]) begin
        w = (streak > 0 && streak < int'(HM)) ? last : 1 - last;
        eg[0] = (w == 0); eg[1] = (w == 1);
      end else begin
        eg[0] = busy[0]; eg[1] = busy[1];
      end
      @(negedge clk);
      ow[0] = m0_waitrequest;   ow[1] = m1_waitrequest;
      ov[0] = m0_readdatavalid; ov[1] = m1_readdatavalid;
      od[0] = m0_readdata;      od[1] = m1_readdata;
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (ow[m] !== (busy[m] & ~eg[m])) begin
          n_fail++; $display("FAIL rnd_wait%0d cycle %0d: got %b expected %b", m, cyc, ow[m], busy[m] & ~eg[m]);
        end
        n_checks++;
        if (ov[m] !== exp_v[m] || (exp_v[m] && od[m] !== exp_d[m])) begin
          n_fail++; $display("FAIL rnd_read%0d cycle %0d: valid=%b data=%h expected %b %h",
                             m, cyc, ov[m], od[m], exp_v[m], exp_d[m]);
        end
      end
      n_checks++;
      if (mem_chipselect !== (eg[0] | eg[1]) ||
          ((eg[0] | eg[1]) && (mem_address !== ad[eg[1] ? 1 : 0] || mem_write !== op_wr[eg[1] ? 1 : 0]))) begin
        n_fail++; $display("FAIL rnd_mem cycle %0d: cs=%b addr=%h we=%b", cyc, mem_chipselect, mem_address, mem_write);
      end
      for (int m = 0; m < 2; m++) begin
        nxt_v[m] = 1'b0; nxt_d[m] = '0;
        if (eg[m]) begin
          if (op_wr[m]) begin
            for (int b = 0; b < int'(BW); b++)
              if (be[m][b]) gold[ad[m]][8*b +: 8] = wd[m][8*b +: 8];
          end else begin
            nxt_v[m] = 1'b1; nxt_d[m] = gold[ad[m]];
          end
          busy[m] = 1'b0; wc[m] = 0;
          streak = (last == m && streak > 0) ? streak + 1 : 1;
          last = m;
        end else if (busy[m]) begin
          wc[m]++;
          n_checks++;
          if (wc[m] > int'(HM)) begin
            n_fail++; $display("FAIL rnd_starve%0d cycle %0d: waited %0d cycles", m, cyc, wc[m]);
          end
        end
      end
      if (!eg[0] && !eg[1]) streak = 0;
      exp_v = nxt_v; exp_d = nxt_d;
      @(posedge clk); #1;
    end
    idle_all();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) gold[i] = DW'(i * 3);
    test_reset();
    test_write_read();
    test_tie_after_reset();
    test_round_robin();
    test_byte_merge();
    test_reset_outstanding();
    test_read_write_both();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
